// File: rtl/pi_regulator.sv
// PI regulator stage: one shared multiplier sequenced by a five-state FSM,
// clamping anti-windup integrator, and a saturated, registered control word.
module pi_regulator #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] error_in,
  input  logic                  error_valid,
  output logic                  error_ready,
  input  logic [COEF_WIDTH-1:0] kp,
  input  logic [COEF_WIDTH-1:0] ki,
  input  logic [DATA_WIDTH-1:0] out_min,
  input  logic [DATA_WIDTH-1:0] out_max,
  output logic [DATA_WIDTH-1:0] control_out,
  output logic                  control_valid,
  output logic                  saturated,
  output logic                  overrun
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;

  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, INTEG, OUTPUT} state_e;

  state_e state_q, state_d;

  logic signed [DW-1:0] err_q, err_d;
  logic signed [AW-1:0] p_term_q, p_term_d;
  logic signed [AW-1:0] i_inc_q, i_inc_d;
  logic signed [AW-1:0] integ_q, integ_d;
  logic        [DW-1:0] control_out_q, control_out_d;
  logic                 control_valid_q, control_valid_d;
  logic                 saturated_q, saturated_d;
  logic                 overrun_q, overrun_d;

  logic signed [AW-1:0] mul_a, mul_b, prod, prod_sh;
  logic signed [AW:0]   lo_ext, hi_ext, integ_sum, out_sum;
  logic signed [DW-1:0] integ_clamp, out_clamp;

  // out_max is tested first so it wins when the limits are inverted.
  function automatic logic signed [DW-1:0] clamp(input logic signed [AW:0] v,
                                                 input logic signed [AW:0] lo,
                                                 input logic signed [AW:0] hi);
    if (v > hi)      return hi[DW-1:0];
    else if (v < lo) return lo[DW-1:0];
    else             return v[DW-1:0];
  endfunction

  // Shared multiplier: signed error times zero-extended gain.
  always_comb begin
    mul_a   = {{(AW-DW){err_q[DW-1]}}, err_q};
    mul_b   = {{(AW-COEF_WIDTH){1'b0}}, (state_q == MUL_P) ? kp : ki};
    prod    = mul_a * mul_b;
    prod_sh = prod >>> FRAC_BITS;
  end

  always_comb begin
    lo_ext      = {{(AW+1-DW){out_min[DW-1]}}, out_min};
    hi_ext      = {{(AW+1-DW){out_max[DW-1]}}, out_max};
    integ_sum   = {integ_q[AW-1], integ_q} + {i_inc_q[AW-1], i_inc_q};
    out_sum     = {p_term_q[AW-1], p_term_q} + {integ_q[AW-1], integ_q};
    integ_clamp = clamp(integ_sum, lo_ext, hi_ext);
    out_clamp   = clamp(out_sum, lo_ext, hi_ext);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      err_q           <= '0;
      p_term_q        <= '0;
      i_inc_q         <= '0;
      integ_q         <= '0;
      control_out_q   <= '0;
      control_valid_q <= 1'b0;
      saturated_q     <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      err_q           <= err_d;
      p_term_q        <= p_term_d;
      i_inc_q         <= i_inc_d;
      integ_q         <= integ_d;
      control_out_q   <= control_out_d;
      control_valid_q <= control_valid_d;
      saturated_q     <= saturated_d;
      overrun_q       <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (error_valid) state_d = MUL_P;
        MUL_P:   state_d = MUL_I;
        MUL_I:   state_d = INTEG;
        INTEG:   state_d = OUTPUT;
        OUTPUT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    err_d           = err_q;
    p_term_d        = p_term_q;
    i_inc_d         = i_inc_q;
    integ_d         = integ_q;
    control_out_d   = control_out_q;
    control_valid_d = 1'b0;
    saturated_d     = saturated_q;
    overrun_d       = 1'b0;
    if (!enable) begin
      integ_d       = '0;
      control_out_d = '0;
      saturated_d   = 1'b0;
    end else begin
      overrun_d = error_valid && (state_q != IDLE);
      case (state_q)
        IDLE:   if (error_valid) err_d = error_in;
        MUL_P:  p_term_d = prod_sh;
        MUL_I:  i_inc_d = prod_sh;
        INTEG:  integ_d = {{(AW-DW){integ_clamp[DW-1]}}, integ_clamp};
        OUTPUT: begin
          control_out_d   = out_clamp;
          saturated_d     = (out_sum < lo_ext) || (out_sum > hi_ext);
          control_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign error_ready   = (state_q == IDLE);
  assign control_out   = control_out_q;
  assign control_valid = control_valid_q;
  assign saturated     = saturated_q;
  assign overrun       = overrun_q;
endmodule

// File: tb/tb_pi_regulator.sv
// Bench for pi_regulator: directed scenarios plus randomized samples checked
// against an arithmetic PI model (floor division, explicit clamping).
module tb_pi_regulator;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        enable = 0;
  logic [15:0] error_in = '0;
  logic        error_valid = 0;
  logic        error_ready;
  logic [15:0] kp = '0, ki = '0, out_min = '0, out_max = '0;
  logic [15:0] control_out;
  logic        control_valid, saturated, overrun;

  int checks = 0, errors = 0;
  longint m_integ = 0;

  pi_regulator dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .error_in(error_in), .error_valid(error_valid), .error_ready(error_ready),
    .kp(kp), .ki(ki), .out_min(out_min), .out_max(out_max),
    .control_out(control_out), .control_valid(control_valid),
    .saturated(saturated), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint lim(input longint v);
    longint lo = longint'($signed(out_min));
    longint hi = longint'($signed(out_max));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: one accepted sample through the PI law.
  task automatic model(input int e, output int o, output logic s);
    longint p, inc, sum;
    p   = floor_div(longint'(e) * longint'(kp), 256);
    inc = floor_div(longint'(e) * longint'(ki), 256);
    m_integ = lim(m_integ + inc);
    sum = p + m_integ;
    o = int'(lim(sum));
    s = (sum < longint'($signed(out_min))) || (sum > longint'($signed(out_max)));
  endtask

  task automatic set_cfg(input int kp_i, input int ki_i, input int lo, input int hi);
    kp = 16'(kp_i); ki = 16'(ki_i); out_min = 16'(lo); out_max = 16'(hi);
  endtask

  task automatic clear_integ();
    enable = 0; step(); enable = 1; m_integ = 0;
  endtask

  // Offers one sample from IDLE and waits (bounded) for control_valid.
  task automatic send(input int e, output int o, output logic s, output int lat);
    error_in = 16'(e); error_valid = 1;
    step();
    error_valid = 0; lat = 0;
    while (control_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    o = int'($signed(control_out)); s = saturated;
  endtask

  task automatic test_reset();
    checks++; if ({control_out, control_valid, saturated, overrun} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs: got %h/%b/%b/%b want 0", control_out, control_valid, saturated, overrun); end
    checks++; if (error_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", error_ready); end
  endtask

  task automatic test_basic();
    int o, lat, eo; logic s, es;
    set_cfg(256, 128, -1000, 1000); clear_integ();
    send(100, o, s, lat); model(100, eo, es);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", lat); end
    checks++; if (o !== 150 || o !== eo || s !== 1'b0) begin
      errors++; $display("FAIL basic_first: got %0d sat %b want 150 sat 0", o, s); end
    step();
    checks++; if (control_valid !== 1'b0 || int'($signed(control_out)) !== 150) begin
      errors++; $display("FAIL basic_pulse: valid %b out %0d want 0 / held 150", control_valid, $signed(control_out)); end
    send(100, o, s, lat); model(100, eo, es);
    checks++; if (o !== 200 || o !== eo) begin errors++; $display("FAIL basic_second: got %0d want 200", o); end
    step();
  endtask

  task automatic test_neg_floor();
    int o, lat, eo; logic s, es;
    set_cfg(256, 128, -1000, 1000); clear_integ();
    send(-3, o, s, lat); model(-3, eo, es);
    checks++; if (o !== -5 || o !== eo || s !== 1'b0) begin
      errors++; $display("FAIL neg_floor: got %0d sat %b want -5 sat 0", o, s); end
    step();
  endtask

  task automatic test_saturation();
    int o, lat, eo; logic s, es;
    set_cfg(256, 256, -1000, 1000); clear_integ();
    send(2000, o, s, lat); model(2000, eo, es);
    checks++; if (o !== 1000 || s !== 1'b1 || m_integ !== 1000) begin
      errors++; $display("FAIL sat_high: got %0d sat %b want 1000 sat 1", o, s); end
    step();
    send(-100, o, s, lat); model(-100, eo, es);
    checks++; if (o !== 800 || o !== eo || s !== 1'b0) begin
      errors++; $display("FAIL antiwindup: got %0d sat %b want 800 sat 0", o, s); end
    step();
  endtask

  task automatic test_bounds();
    int o, lat, eo; logic s, es;
    set_cfg(256, 0, -1000, 1000); clear_integ();
    send(1000, o, s, lat); model(1000, eo, es);
    checks++; if (o !== 1000 || s !== 1'b0) begin
      errors++; $display("FAIL bound_inclusive_hi: got %0d sat %b want 1000 sat 0", o, s); end
    step();
    send(-1000, o, s, lat); model(-1000, eo, es);
    checks++; if (o !== -1000 || s !== 1'b0) begin
      errors++; $display("FAIL bound_inclusive_lo: got %0d sat %b want -1000 sat 0", o, s); end
    step();
    send(1001, o, s, lat); model(1001, eo, es);
    checks++; if (o !== 1000 || s !== 1'b1) begin
      errors++; $display("FAIL bound_over: got %0d sat %b want 1000 sat 1", o, s); end
    step();
    set_cfg(256, 0, 100, -100); clear_integ();
    send(50, o, s, lat); model(50, eo, es);
    checks++; if (o !== -100 || o !== eo || s !== es) begin
      errors++; $display("FAIL inverted_limits: got %0d sat %b want %0d sat %b", o, s, eo, es); end
    step();
  endtask

  task automatic test_overrun();
    int vals[25]; int acc = 0, eo; logic es;
    set_cfg(256, 128, -1000, 1000); clear_integ();
    foreach (vals[i]) vals[i] = int'($urandom_range(0, 1000)) - 500;
    error_valid = 1;
    for (int k = 0; k < 25; k++) begin
      error_in = 16'(vals[k]);
      step();
      if (k % 5 == 0) acc = vals[k];
      checks++; if (overrun !== (k % 5 != 0)) begin
        errors++; $display("FAIL overrun_flag k=%0d: got %b want %b", k, overrun, (k % 5 != 0)); end
      if (k % 5 == 4) begin
        model(acc, eo, es);
        checks++; if (control_valid !== 1'b1 || int'($signed(control_out)) !== eo) begin
          errors++; $display("FAIL overrun_out k=%0d: valid %b out %0d want 1 / %0d", k, control_valid, $signed(control_out), eo); end
      end else begin
        checks++; if (control_valid !== 1'b0) begin
          errors++; $display("FAIL overrun_novalid k=%0d: got %b want 0", k, control_valid); end
      end
    end
    error_valid = 0; step();
  endtask

  task automatic test_enable_drop();
    int o, lat, eo; logic s, es;
    set_cfg(256, 128, -1000, 1000); clear_integ();
    send(300, o, s, lat); model(300, eo, es);
    step();
    error_in = 16'(40); error_valid = 1; step(); error_valid = 0;
    step();
    enable = 0; step();
    checks++; if (control_out !== 16'd0 || control_valid !== 1'b0 || saturated !== 1'b0 || error_ready !== 1'b1) begin
      errors++; $display("FAIL enable_drop: out %0d valid %b sat %b ready %b want 0/0/0/1", $signed(control_out), control_valid, saturated, error_ready); end
    error_valid = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++; if (control_valid !== 1'b0 || overrun !== 1'b0) begin
        errors++; $display("FAIL disabled_quiet k=%0d: valid %b overrun %b want 0/0", k, control_valid, overrun); end
    end
    error_valid = 0; enable = 1; m_integ = 0;
    send(100, o, s, lat); model(100, eo, es);
    checks++; if (o !== 150 || o !== eo) begin errors++; $display("FAIL reenable: got %0d want 150", o); end
    step();
  endtask

  task automatic test_reset_mid();
    int o, lat, eo; logic s, es;
    set_cfg(256, 128, -1000, 1000); clear_integ();
    send(1000, o, s, lat); model(1000, eo, es);
    checks++; if (m_integ !== 500 || o !== eo) begin errors++; $display("FAIL pre_reset: got %0d want %0d", o, eo); end
    step();
    error_in = 16'(100); error_valid = 1; step(); error_valid = 0;
    step(); step();
    reset_n = 0; step();
    checks++; if ({control_out, control_valid, saturated, overrun} !== 19'd0 || error_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: out %0d valid %b sat %b ovr %b want all 0", $signed(control_out), control_valid, saturated, overrun); end
    reset_n = 1; m_integ = 0;
    send(100, o, s, lat); model(100, eo, es);
    checks++; if (o !== 150 || o !== eo) begin errors++; $display("FAIL post_reset: got %0d want 150", o); end
    step();
  endtask

  task automatic test_random();
    int o, lat, eo, e, a, b; logic s, es;
    a = int'($urandom_range(0, 4000)) - 4000;
    b = int'($urandom_range(0, 4000)) + 1;
    set_cfg(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), a, b);
    clear_integ();
    for (int k = 0; k < 30; k++) begin
      e = int'($urandom_range(0, 65535)) - 32768;
      send(e, o, s, lat); model(e, eo, es);
      checks++; if (o !== eo || s !== es || lat !== 4) begin
        errors++; $display("FAIL random k=%0d e=%0d: got %0d sat %b lat %0d want %0d sat %b lat 4", k, e, o, s, lat, eo, es); end
      step();
    end
  endtask

  initial begin
    step(); step();
    test_reset();
    reset_n = 1; enable = 1; step();
    test_basic();
    test_neg_floor();
    test_saturation();
    test_bounds();
    test_overrun();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
